cpu_sequencer: RTL and testbench

Fetch/decode/execute control state machine for the 8-bit accumulator CPU. It drives the instruction register load strobe, the program counter, and the accumulator/ALU/register-file controls. It consumes the 4-bit opcode held by the instruction register, which captures on the falling clock edge. It also handshakes with instruction memory and exposes a retired-instruction counter for debug.

---
 rtl/cpu_sequencer.sv | 139 +++++++++++++
 tb/tb_cpu_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Fetch/decode/execute control FSM for the 8-bit accumulator CPU.
//            Optional single-step state enabled by CPU_SEQ_SINGLE_STEP_EN.
// Revision : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clb,
    input  logic             imem_ready,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [3:0]       opcode,
    input  logic             zero_flag,
    output logic             imem_req,
    output logic             load_ir,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             acc_load,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic             halted,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4,
        ST_STEP   = 3'd5
    } state_t;

    localparam logic [2:0]       C_ALU_PASS = 3'd0;
    localparam logic [2:0]       C_ALU_ADD  = 3'd1;
    localparam logic [2:0]       C_ALU_SUB  = 3'd2;
    localparam logic [2:0]       C_ALU_AND  = 3'd3;
    localparam logic [2:0]       C_ALU_OR   = 3'd4;
    localparam logic [2:0]       C_ALU_XOR  = 3'd5;
    localparam logic [3:0]       C_OP_HLT   = 4'hF;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            state_q <= ST_RST;
            op_q    <= 4'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        imem_req    = 1'b0;
        load_ir     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        acc_load    = 1'b0;
        alu_op      = C_ALU_PASS;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_RST: state_d = ST_FETCH;

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    load_ir = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            // IR settled on the falling edge of the fetch cycle, so it is safe to latch here.
            ST_DECODE: begin
                op_d    = opcode;
                state_d = (opcode == C_OP_HLT) ? ST_HALT : ST_EXEC;
            end

            ST_EXEC: begin
                cnt_d = cnt_q + C_CNT_ONE;
`ifdef CPU_SEQ_SINGLE_STEP_EN
                state_d = ST_STEP;
`else
                state_d = ST_FETCH;
`endif
                case (op_q)
                    4'h1: begin acc_load = 1'b1; alu_op = C_ALU_PASS; alu_src_imm = 1'b1; end
                    4'h2: begin acc_load = 1'b1; alu_op = C_ALU_PASS; end
                    4'h3: reg_we = 1'b1;
                    4'h4: begin acc_load = 1'b1; alu_op = C_ALU_ADD; end
                    4'h5: begin acc_load = 1'b1; alu_op = C_ALU_SUB; end
                    4'h6: begin acc_load = 1'b1; alu_op = C_ALU_AND; end
                    4'h7: begin acc_load = 1'b1; alu_op = C_ALU_OR;  end
                    4'h8: begin acc_load = 1'b1; alu_op = C_ALU_XOR; end
                    4'h9: begin acc_load = 1'b1; alu_op = C_ALU_ADD; alu_src_imm = 1'b1; end
                    4'hA: pc_load = 1'b1;
                    4'hB: pc_load = zero_flag;
                    default: ;
                endcase
            end

            ST_HALT: halted = 1'b1;

`ifdef CPU_SEQ_SINGLE_STEP_EN
            ST_STEP: begin
                if (step) begin
                    state_d = ST_FETCH;
                end
            end
`endif

            default: state_d = ST_RST;
        endcase
    end

    assign state_dbg   = state_q;
    assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Brief    : Randomized self-checking bench for cpu_sequencer with an
//            instruction-level expected-trace model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam int CNT_W = 6;

    typedef struct packed {
        logic             imem_req;
        logic             load_ir;
        logic             pc_inc;
        logic             pc_load;
        logic             acc_load;
        logic [2:0]       alu_op;
        logic             alu_src_imm;
        logic             reg_we;
        logic             halted;
        logic [2:0]       state;
        logic [CNT_W-1:0] cnt;
    } outs_t;

    logic             clk = 1'b0;
    logic             clb;
    logic             imem_ready;
    logic             step;
    logic [3:0]       opcode;
    logic             zero_flag;
    logic             imem_req, load_ir, pc_inc, pc_load, acc_load;
    logic [2:0]       alu_op;
    logic             alu_src_imm, reg_we, halted;
    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_count = 0;
    bit log_en = 1'b0;
    outs_t exp_q[$];
    int    cyc_q[$];
    int    ldir_cycles[$];

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clb         (clb),
        .imem_ready  (imem_ready),
`ifdef CPU_SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .opcode      (opcode),
        .zero_flag   (zero_flag),
        .imem_req    (imem_req),
        .load_ir     (load_ir),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .acc_load    (acc_load),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_we      (reg_we),
        .halted      (halted),
        .state_dbg   (state_dbg),
        .instr_count (instr_count)
    );

    function automatic outs_t dut_outs();
        outs_t o;
        o = '{imem_req, load_ir, pc_inc, pc_load, acc_load, alu_op,
              alu_src_imm, reg_we, halted, state_dbg, instr_count};
        return o;
    endfunction

    function automatic outs_t base(input int st);
        outs_t o;
        o       = '0;
        o.state = st[2:0];
        o.cnt   = model_count[CNT_W-1:0];
        return o;
    endfunction

    // Opcode control table: what an EXEC cycle must show for a given instruction.
    function automatic outs_t exec_ctrl(input int op, input bit zf);
        outs_t o;
        o = base(3);
        case (op)
            1:        begin o.acc_load = 1; o.alu_op = 0; o.alu_src_imm = 1; end
            2:        begin o.acc_load = 1; o.alu_op = 0; end
            3:        o.reg_we = 1;
            4, 5, 6, 7, 8: begin o.acc_load = 1; o.alu_op = 3'(op - 3); end
            9:        begin o.acc_load = 1; o.alu_op = 1; o.alu_src_imm = 1; end
            10:       o.pc_load = 1;
            11:       o.pc_load = zf;
            default:  ;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        outs_t e, a;
        int c;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            a = dut_outs();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL trace cyc=%0d got=%h exp=%h", c, a, e);
            end
            if (log_en && a.load_ir) ldir_cycles.push_back(c);
        end
    end

    task automatic check_now(input string name, input outs_t e);
        outs_t a;
        a = dut_outs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, a, e);
        end
    endtask

    task automatic check_val(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, expv);
        end
    endtask

    task automatic push_cycle(input outs_t e);
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic finish_reset();
        model_count = 0;
        push_cycle(base(0));
        clb = 1'b1;
        cyc = 0;
        push_cycle(base(0));
    endtask

    task automatic do_reset(input int hold);
        clb        = 1'b0;
        imem_ready = 1'($urandom);
        model_count = 0;
        for (int i = 0; i < hold; i++) push_cycle(base(0));
        finish_reset();
    endtask

    // abort=1 pulls clb low in the middle of the EXEC cycle.
    task automatic run_instr(input int op, input int stalls, input bit zf, input bit abort);
        outs_t e;
        for (int i = 0; i < stalls; i++) begin
            imem_ready = 1'b0;
            zero_flag  = 1'($urandom);
            step       = 1'($urandom);
            e = base(1);
            e.imem_req = 1;
            push_cycle(e);
        end
        imem_ready = 1'b1;
        opcode     = op[3:0];
        step       = 1'($urandom);
        e = base(1);
        e.imem_req = 1; e.load_ir = 1; e.pc_inc = 1;
        push_cycle(e);
        imem_ready = 1'($urandom);
        step       = 1'($urandom);
        push_cycle(base(2));
        if (op == 15) begin
            for (int i = 0; i < 3; i++) begin
                imem_ready = 1'($urandom);
                e = base(4);
                e.halted = 1;
                push_cycle(e);
            end
            return;
        end
        zero_flag = zf;
        opcode    = 4'($urandom);
        step      = 1'($urandom);
        e = exec_ctrl(op, zf);
        if (abort) begin
            #1;
            check_now("pre_abort_exec", e);
            #1 clb = 1'b0;
            #1;
            model_count = 0;
            check_now("async_rst_exec", base(0));
            push_cycle(base(0));
            finish_reset();
            return;
        end
        push_cycle(e);
        model_count = (model_count + 1) % (1 << CNT_W);
`ifdef CPU_SEQ_SINGLE_STEP_EN
        step = 1'b0;
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) push_cycle(base(5));
        step = 1'b1;
        push_cycle(base(5));
        step = 1'b0;
`endif
    endtask

    task automatic fetch_abort();
        outs_t e;
        imem_ready = 1'b0;
        e = base(1);
        e.imem_req = 1;
        push_cycle(e);
        #1;
        check_now("pre_abort_fetch", e);
        #1 clb = 1'b0;
        #1;
        model_count = 0;
        check_now("async_rst_fetch", base(0));
        push_cycle(base(0));
        finish_reset();
    endtask

    initial begin
        int exp_ld[4];
        int op;
        exp_ld = '{1, 4, 7, 10};
        clb = 1'b0; imem_ready = 1'b0; step = 1'b0; opcode = 4'h0; zero_flag = 1'b0;
        @(posedge clk);
        #1;
        check_now("reset_state", base(0));
        do_reset(2);

        // Directed program LDI, ADDI, STR, HLT with memory always ready.
        log_en = 1'b1;
        run_instr(1, 0, 0, 0);
        run_instr(9, 0, 0, 0);
        run_instr(3, 0, 0, 0);
        run_instr(15, 0, 0, 0);
        log_en = 1'b0;
`ifndef CPU_SEQ_SINGLE_STEP_EN
        check_val("load_ir_count", ldir_cycles.size(), 4);
        for (int i = 0; i < 4; i++)
            check_val("load_ir_cycle", (i < ldir_cycles.size()) ? ldir_cycles[i] : -1, exp_ld[i]);
`endif
        check_val("halt_state", int'(state_dbg), 4);
        check_val("halt_flag", int'(halted), 1);
        check_val("halt_count", int'(instr_count), 3);

        do_reset(1);
        run_instr(0, 5, 0, 0);
        run_instr(11, 0, 1, 0);
        run_instr(11, 0, 0, 0);
        run_instr(10, 1, 0, 0);
        check_val("count_after_jz", int'(instr_count), 4);
        fetch_abort();
        check_val("count_after_fetch_abort", int'(instr_count), 0);
        run_instr(4, 0, 0, 0);
        run_instr(2, 2, 0, 1);

        // Counter wrap at 2^CNT_W retirements.
        for (int i = 0; i < (1 << CNT_W) - 1; i++) run_instr(0, 0, 0, 0);
        check_val("count_all_ones", int'(instr_count), (1 << CNT_W) - 1);
        run_instr(0, 0, 0, 0);
        check_val("count_wrap", int'(instr_count), 0);

        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 29) == 0) ? 15 : int'($urandom_range(0, 14));
            if ($urandom_range(0, 24) == 0) begin
                fetch_abort();
            end else begin
                run_instr(op, int'($urandom_range(0, 3)), 1'($urandom),
                          ($urandom_range(0, 24) == 0) && (op != 15));
                if (op == 15) do_reset(int'($urandom_range(1, 2)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
